// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, register-zero constant, ALU op codes and the packed ID/EX control word
package pipe_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int ALUOP_W = 4;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7
  } alu_op_t;
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;
  localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard between the ID instruction and a load sitting in EX
module load_use_detect #(
  parameter int ADDR_W = 5
) (
  input  logic              id_valid,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [ADDR_W-1:0] ex_dest,
  output logic              hz
);
  import pipe_pkg::*;
  logic ex_load;
  logic src_match;
  assign ex_load = ex_valid & ex_mem_read & (ex_dest != REG_ZERO);
  assign src_match = (id_uses_rs & (id_rs_addr == ex_dest)) | (id_uses_rt & (id_rt_addr == ex_dest));
  assign hz = ex_load & src_match & id_valid;
endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX register with load-use bubble insertion, flush and EX hold.
// IDEX_PERF_CNT_EN adds a saturating count of hazard bubbles on bubble_cnt_o.
module id_ex_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid_i,
  input  logic [DATA_W-1:0]  id_rs_data_i,
  input  logic [DATA_W-1:0]  id_rt_data_i,
  input  logic [DATA_W-1:0]  id_imm_i,
  input  logic [ADDR_W-1:0]  id_rs_addr_i,
  input  logic [ADDR_W-1:0]  id_rt_addr_i,
  input  logic [ADDR_W-1:0]  id_rd_addr_i,
  input  logic               id_uses_rs_i,
  input  logic               id_uses_rt_i,
  input  logic               id_reg_write_i,
  input  logic               id_mem_read_i,
  input  logic               id_mem_write_i,
  input  logic               id_mem_to_reg_i,
  input  logic               id_alu_src_i,
  input  logic               id_reg_dst_i,
  input  logic [ALUOP_W-1:0] id_alu_op_i,
  input  logic               flush_i,
  input  logic               ex_hold_i,
  output logic               stall_o,
  output logic               ex_valid_o,
  output logic [DATA_W-1:0]  ex_rs_data_o,
  output logic [DATA_W-1:0]  ex_rt_data_o,
  output logic [DATA_W-1:0]  ex_imm_o,
  output logic [ADDR_W-1:0]  ex_rs_addr_o,
  output logic [ADDR_W-1:0]  ex_rt_addr_o,
  output logic [ADDR_W-1:0]  ex_dest_o,
  output logic               ex_reg_write_o,
  output logic               ex_mem_read_o,
  output logic               ex_mem_write_o,
  output logic               ex_mem_to_reg_o,
  output logic               ex_alu_src_o,
`ifdef IDEX_PERF_CNT_EN
  output logic [31:0]        bubble_cnt_o,
`endif
  output logic [ALUOP_W-1:0] ex_alu_op_o
);
  import pipe_pkg::*;
  logic hz;
  logic load_id;
  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  load_use_detect #(.ADDR_W(ADDR_W)) u_detect (
    .id_valid    (id_valid_i),
    .id_uses_rs  (id_uses_rs_i),
    .id_uses_rt  (id_uses_rt_i),
    .id_rs_addr  (id_rs_addr_i),
    .id_rt_addr  (id_rt_addr_i),
    .ex_valid    (ex_valid_o),
    .ex_mem_read (ex_mem_read_o),
    .ex_dest     (ex_dest_o),
    .hz          (hz)
  );
  assign stall_o = ex_hold_i | (hz & ~flush_i);
  // flush, hazard and an empty ID slot all collapse to the same all-zero bubble
  assign load_id = id_valid_i & ~flush_i & ~hz;
  assign id_ctrl = '{reg_write: id_reg_write_i, mem_read: id_mem_read_i, mem_write: id_mem_write_i,
                     mem_to_reg: id_mem_to_reg_i, alu_src: id_alu_src_i, alu_op: id_alu_op_i};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_o   <= 1'b0;
      ex_rs_data_o <= '0;
      ex_rt_data_o <= '0;
      ex_imm_o     <= '0;
      ex_rs_addr_o <= '0;
      ex_rt_addr_o <= '0;
      ex_dest_o    <= '0;
      ex_ctrl      <= CTRL_BUBBLE;
    end else if (!ex_hold_i) begin
      ex_valid_o   <= load_id;
      ex_rs_data_o <= load_id ? id_rs_data_i : '0;
      ex_rt_data_o <= load_id ? id_rt_data_i : '0;
      ex_imm_o     <= load_id ? id_imm_i : '0;
      ex_rs_addr_o <= load_id ? id_rs_addr_i : '0;
      ex_rt_addr_o <= load_id ? id_rt_addr_i : '0;
      ex_dest_o    <= load_id ? (id_reg_dst_i ? id_rd_addr_i : id_rt_addr_i) : '0;
      ex_ctrl      <= load_id ? id_ctrl : CTRL_BUBBLE;
    end
  end
  assign ex_reg_write_o  = ex_ctrl.reg_write;
  assign ex_mem_read_o   = ex_ctrl.mem_read;
  assign ex_mem_write_o  = ex_ctrl.mem_write;
  assign ex_mem_to_reg_o = ex_ctrl.mem_to_reg;
  assign ex_alu_src_o    = ex_ctrl.alu_src;
  assign ex_alu_op_o     = ex_ctrl.alu_op;
`ifdef IDEX_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bubble_cnt_o <= '0;
    else if (!ex_hold_i && !flush_i && hz && !(&bubble_cnt_o)) bubble_cnt_o <= bubble_cnt_o + 32'd1;
  end
`endif
endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register with integrated load-use hazard detection.
- Sits directly downstream of the register file (ID stage) and feeds the EX stage.
- Latches ID-stage operands, immediate and control word; inserts bubbles on load-use hazards and on flush; freezes on an EX-side hold.
- Drives stall_o back to the PC and IF/ID registers.

Parameters:
- DATA_W, 32, operand/immediate width
- ADDR_W, 5, register address width
- ALUOP_W, 4, ALU operation code width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_valid_i  in  1  ID holds a real instruction
- id_rs_data_i, id_rt_data_i  in  DATA_W  register-file read data (already WB-bypassed)
- id_imm_i  in  DATA_W  sign/zero-extended immediate
- id_rs_addr_i, id_rt_addr_i, id_rd_addr_i  in  ADDR_W  source/destination fields
- id_uses_rs_i, id_uses_rt_i  in  1  instruction actually reads rs/rt
- id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i, id_alu_src_i, id_reg_dst_i  in  1  decoded control
- id_alu_op_i  in  ALUOP_W  ALU operation
- flush_i  in  1  kill the instruction currently in ID (branch/jump taken)
- ex_hold_i  in  1  EX cannot accept (multi-cycle op); freeze
- stall_o  out  1  freeze PC and IF/ID this cycle
- ex_valid_o  out  1  EX-stage instruction valid
- ex_rs_data_o, ex_rt_data_o, ex_imm_o  out  DATA_W  registered operands
- ex_rs_addr_o, ex_rt_addr_o  out  ADDR_W  registered sources (for forwarding unit)
- ex_dest_o  out  ADDR_W  registered destination = id_reg_dst_i ? rd : rt
- ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o, ex_alu_src_o  out  1  registered control
- ex_alu_op_o  out  ALUOP_W  registered ALU op

Behaviour:
- Reset (async, immediate): every registered output = 0. stall_o therefore reads 0 after reset.
- Latency: one cycle, ID inputs to ex_* outputs on the rising clk edge.
- Load-use hazard (combinational), hz =
  - ex_valid_o & ex_mem_read_o & ex_dest_o != 0, AND
  - ((id_uses_rs_i & id_rs_addr_i == ex_dest_o) | (id_uses_rt_i & id_rt_addr_i == ex_dest_o)), AND
  - id_valid_i.
- stall_o = ex_hold_i | (hz & ~flush_i).
- Per-edge priority, highest first:
  1. ex_hold_i=1: all ex_* registers keep their value (flush_i and hz ignored this cycle; upstream frozen via stall_o).
  2. flush_i=1: load a bubble.
  3. hz=1: load a bubble. IF/ID is held, so the same instruction re-presents next cycle.
  4. Otherwise: load ID inputs; ex_valid_o = id_valid_i.
- Bubble:
  - ex_valid_o and all control outputs = 0.
  - Data, address and alu_op fields = 0 (deterministic for verification).
- id_valid_i=0 with no hold/flush/hz: load a bubble (identical encoding).
- Destination $0: ex_dest_o may be 0. It never triggers hz; ex_reg_write_o passes through unchanged (the register file ignores writes to $0).
- Stall length: a load-use stall lasts exactly one cycle, because the bubble clears ex_mem_read_o. Back-to-back dependent loads each stall once.
- Reset mid-stall: all state clears; stall_o drops in the same cycle rst asserts.
- Store data dependency (rt of a store on a prior load) counts as hz when id_uses_rt_i=1. No MEM-side forwarding is assumed.

Optional Feature:
- Macro IDEX_PERF_CNT_EN.
- Defined:
  - Adds output bubble_cnt_o (32 bits), reset 0.
  - Increments by 1 on each edge where a bubble is loaded due to hz (not flush, not invalid, not hold).
  - Saturates at 0xFFFFFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - REG_ZERO constant (5'd0).
  - ALU op encodings.
  - Width constants DATA_W/ADDR_W/ALUOP_W.
  - Packed control-word typedef ctrl_t (reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op) and CTRL_BUBBLE = all-zero.
- One sub-module: load_use_detect, purely combinational; computes hz from the ID fields and the EX-registered fields. id_ex_pipe owns all flops and the priority logic.

Test Plan:
- Reset: assert rst mid-cycle with registers loaded -> all ex_* = 0 and stall_o = 0 immediately, held until release.
- Passthrough: lw-free add, rs_data=0x11, rt_data=0x22, rd=3, reg_dst=1 -> next edge ex_dest_o=3, ex_rs_data_o=0x11, ex_valid_o=1, stall_o=0.
- Load-use:
  - Stimulus: lw $5 in EX, then add uses rs=5.
  - Response: stall_o=1 for one cycle, and a bubble is loaded (ex_valid_o=0, all control 0).
  - Next cycle the add is latched with stall_o=0. With IDEX_PERF_CNT_EN, bubble_cnt_o increments 0->1.
- Zero-dest/unused-source: lw $0 then use $0 -> no stall. lw $7 then instruction with id_uses_rt_i=0 and rt=7 -> no stall.
- Flush vs hazard: hz=1 and flush_i=1 in the same cycle -> stall_o=0, bubble loaded, counter unchanged.
- Hold:
  - ex_hold_i=1 for 3 cycles while hz=1 and flush_i=1 -> ex_* frozen and stall_o=1 throughout.
  - After release, the hazard rule applies on the first free edge.
